// File: rtl/spi_wr_pkg.sv
// rtl/spi_wr_pkg.sv - frame layout constants, FSM state type and frame builder for the SPI register writer
package spi_wr_pkg;

  localparam int FRAME_W   = 16;
  localparam int WRITE_BIT = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 8;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  // Write frame: write flag, then address, then data, MSB first on the wire
  function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period counter producing rise/fall strobes while enabled
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             phase_hi;
  logic             toggle;

  // A toggle is due when the current half-period has run its CLK_DIV cycles
  assign toggle   = en && (half_cnt == '0);
  assign rise_stb = toggle && !phase_hi;
  assign fall_stb = toggle && phase_hi;

  // Count down each half-period; reload on every toggle so the phase never wraps mid-count
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      half_cnt <= RELOAD;
      phase_hi <= 1'b0;
    end else if (toggle) begin
      half_cnt <= RELOAD;
      phase_hi <= !phase_hi;
    end else begin
      half_cnt <= half_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_writer.sv
// rtl/spi_reg_writer.sv - SPI mode-0 register-write frame controller; SPI_WR_ADDR_CHECK_EN enables address rejection
module spi_reg_writer
  import spi_wr_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4,
  parameter int MAX_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              sclk,
  output logic              ncs,
  output logic              copi,
  output logic              busy,
  output logic              done,
  output logic              err
);

  spi_state_t         state;
  logic [FRAME_W-2:0] shreg;
  logic [4:0]         bit_cnt;
  logic [7:0]         wait_cnt;
  logic [FRAME_W-1:0] frame_in;
  logic               accept;
  logic               addr_bad;
  logic               rise_stb;
  logic               fall_stb;

  assign frame_in = build_frame(req_addr, req_data);
  assign accept   = req_valid && req_ready;

`ifdef SPI_WR_ADDR_CHECK_EN
  assign addr_bad = (req_addr > ADDR_W'(MAX_ADDR));
`else
  assign addr_bad = 1'b0;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state == SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP, all pin outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_bad) begin
              err <= 1'b1;
            end else begin
              copi      <= frame_in[WRITE_BIT];
              shreg     <= frame_in[FRAME_W-2:0];
              bit_cnt   <= 5'd16;
              ncs       <= 1'b0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              wait_cnt  <= 8'(CS_SETUP - 1);
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          if (wait_cnt == '0) begin
            state <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (rise_stb) begin
            sclk <= 1'b1;
          end else if (fall_stb) begin
            sclk <= 1'b0;
            if (bit_cnt == 5'd1) begin
              bit_cnt  <= '0;
              wait_cnt <= 8'(CS_HOLD - 1);
              state    <= HOLD;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              copi    <= shreg[FRAME_W-2];
              shreg   <= {shreg[FRAME_W-3:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (wait_cnt == '0) begin
            ncs      <= 1'b1;
            done     <= 1'b1;
            copi     <= 1'b0;
            wait_cnt <= 8'(CS_IDLE - 1);
            state    <= GAP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        GAP: begin
          if (wait_cnt == '0) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// tb/tb_spi_reg_writer.sv - self-checking bench for spi_reg_writer
module tb_spi_reg_writer;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int MAX_ADDR = 4;
  localparam int LAT      = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int B_DIV    = 2;
  localparam int LAT_B    = 1 + CS_SETUP + 32 * B_DIV + CS_HOLD;
  localparam int LIM      = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, sclk, ncs, copi, busy, done, err;

  logic       valid_b = 1'b0;
  logic [6:0] addr_b = '0;
  logic [7:0] data_b = '0;
  logic       ready_b, sclk_b, ncs_b, copi_b, busy_b, done_b, err_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_reg_writer #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .MAX_ADDR(MAX_ADDR)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .sclk(sclk), .ncs(ncs), .copi(copi), .busy(busy), .done(done), .err(err)
  );

  spi_reg_writer #(
    .CLK_DIV(B_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .MAX_ADDR(MAX_ADDR)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_addr(addr_b), .req_data(data_b),
    .req_ready(ready_b), .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Behavioural SPI peripheral for the main instance: samples COPI on SCLK rise, commits on nCS rise
  logic [15:0] rx_q[$];
  int          rise_q[$];
  logic [7:0]  perif[5];
  logic        m_ps = 1'b0, m_pc = 1'b0, m_pn = 1'b1;
  logic [15:0] m_sh = '0;
  int          mon_bits = 0, m_rises = 0, ncs_hi = 0, ncs_falls = 0, aborted = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_pn && !ncs) begin
        check("ncs_idle_gap_ge4", int'(ncs_hi >= CS_IDLE), 1);
        ncs_falls++;
        mon_bits = 0;
        m_rises  = 0;
        ncs_hi   = 0;
      end
      if (ncs) ncs_hi++;
      if (!m_ps && sclk) begin
        m_sh = {m_sh[14:0], copi};
        mon_bits++;
        m_rises++;
      end
      if (copi !== m_pc) check("copi_change_sclk_low", int'(sclk), 0);
      if (!m_pn && ncs) begin
        if (mon_bits == 16) begin
          rx_q.push_back(m_sh);
          rise_q.push_back(m_rises);
          if (m_sh[15] && m_sh[14:8] <= 7'(MAX_ADDR)) perif[m_sh[10:8]] = m_sh[7:0];
        end else begin
          aborted++;
        end
      end
      m_ps = sclk;
      m_pc = copi;
      m_pn = ncs;
    end
  end

  // Monitor for the CLK_DIV=2 instance: SCLK period and COPI stability
  logic        b_ps = 1'b0, b_pc = 1'b0, b_pn = 1'b1;
  logic [15:0] b_sh = '0, b_frame = '0;
  int          b_last = -1, b_nr = 0, b_rises = 0, b_frames = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (b_pn && !ncs_b) begin
        b_nr   = 0;
        b_last = -1;
      end
      if (!b_ps && sclk_b) begin
        b_sh = {b_sh[14:0], copi_b};
        if (b_last >= 0) check("b_sclk_period", cyc - b_last, 2 * B_DIV);
        b_last = cyc;
        b_nr++;
      end
      if (copi_b !== b_pc) check("b_copi_change_sclk_low", int'(sclk_b), 0);
      if (!b_pn && ncs_b) begin
        b_frame = b_sh;
        b_rises = b_nr;
        b_frames++;
      end
      b_ps = sclk_b;
      b_pc = copi_b;
      b_pn = ncs_b;
    end
  end

  task automatic start_req(input logic [6:0] a, input logic [7:0] d, output int t_acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check("accept_timeout", 1, 0);
    t_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 7'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_done(output int t_done);
    int n;
    n = 0;
    while (!done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check("done_timeout", 1, 0);
    t_done = cyc;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check("ready_timeout", 1, 0);
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_f);
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: actual=no frame required=0x%0h", name, exp_f);
    end else begin
      check({name, "_frame"}, int'(rx_q.pop_front()), int'(exp_f));
      check({name, "_rises"}, rise_q.pop_front(), 16);
    end
  endtask

  task automatic write_frame(input string name, input logic [6:0] a, input logic [7:0] d);
    int ta, td;
    start_req(a, d, ta);
    wait_done(td);
    check({name, "_latency"}, td - ta, LAT);
    @(negedge clk);
    check_frame(name, 16'h8000 | (16'(a) << 8) | 16'(d));
    wait_ready();
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
    logic        exp_err;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_regs[5];
  int         ta, td, ta2, td2, nf0, ab0, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'h00, 8'hA5, 16'h80A5, 1'b0};
    vecs[1] = '{7'h03, 8'h5A, 16'h835A, 1'b0};
    vecs[2] = '{7'h04, 8'hFF, 16'h84FF, 1'b0};
`ifdef SPI_WR_ADDR_CHECK_EN
    vecs[3] = '{7'h05, 8'h11, 16'h8511, 1'b1};
`else
    vecs[3] = '{7'h05, 8'h11, 16'h8511, 1'b0};
`endif
    vecs[4] = '{7'h01, 8'h3C, 16'h813C, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_ncs", int'(ncs), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_copi", int'(copi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(req_ready), 1);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      nf0 = ncs_falls;
      start_req(vecs[i].addr, vecs[i].data, ta);
      check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        repeat (20) @(negedge clk);
        check($sformatf("vec%0d_no_ncs_fall", i), ncs_falls - nf0, 0);
        check($sformatf("vec%0d_ready", i), int'(req_ready), 1);
      end else begin
        wait_done(td);
        check($sformatf("vec%0d_latency", i), td - ta, LAT);
        @(negedge clk);
        check_frame($sformatf("vec%0d", i), vecs[i].exp_frame);
        wait_ready();
      end
    end

    req_valid = 1'b1;
    req_addr  = 7'h03;
    req_data  = 8'h5A;
    @(negedge clk);
    ta = cyc - 1;
    req_addr = 7'h04;
    req_data = 8'hFF;
    wait_done(td);
    check("b2b_first_latency", td - ta, LAT);
    n = 0;
    while (!req_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    ta2 = cyc;
    check("b2b_accept_after_gap", ta2 - td, CS_IDLE);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(td2);
    check("b2b_second_latency", td2 - ta2, LAT);
    @(negedge clk);
    check_frame("b2b_first", 16'h835A);
    check_frame("b2b_second", 16'h84FF);
    wait_ready();

    ab0 = aborted;
    start_req(7'h02, 8'hC3, ta);
    @(negedge clk);
    n = 0;
    while (mon_bits < 9 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check("bit7_timeout", 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ncs", int'(ncs), 1);
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(req_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_aborted", aborted - ab0, 1);
    check("midrst_no_frame", rx_q.size(), 0);
    repeat (4) @(negedge clk);
    write_frame("after_rst", 7'h01, 8'h3C);

    valid_b = 1'b1;
    addr_b  = 7'h02;
    data_b  = 8'h00;
    n = 0;
    while (!ready_b && n < LIM) begin
      @(negedge clk);
      n++;
    end
    ta = cyc;
    @(negedge clk);
    valid_b = 1'b0;
    n = 0;
    while (!done_b && n < LIM) begin
      @(negedge clk);
      n++;
    end
    td = cyc;
    check("div2_latency", td - ta, LAT_B);
    @(negedge clk);
    check("div2_frame", int'(b_frame), 16'h8200);
    check("div2_rises", b_rises, 16);
    check("div2_frames", b_frames, 1);

    for (int a = 0; a < 5; a++) begin
      exp_regs[a] = 8'($urandom);
      write_frame($sformatf("fill%0d", a), 7'(a), exp_regs[a]);
    end
    for (int k = 0; k < 20; k++) begin
      int a;
      logic [7:0] d;
      a = int'($urandom_range(0, 4));
      d = 8'($urandom);
      exp_regs[a] = d;
      write_frame($sformatf("rand%0d", k), 7'(a), d);
    end
    for (int a = 0; a < 5; a++) begin
      check($sformatf("reg%0d", a), int'(perif[a]), int'(exp_regs[a]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
